// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end of the IF stage.
//
// Owns the program counter and drives the word-aligned byte address into the
// instruction memory. The memory answers combinationally in the same cycle,
// and the returned word is captured into the IF/ID holding register. The
// block handles decode stalls, flushes and branch/jump redirects, and counts
// captured instructions for performance debug.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   stall_i          downstream not ready: hold PC and IF/ID
//   flush_i          turn IF/ID into a bubble; PC advances unless stalled
//   redirect_valid_i taken branch/jump; load redirect_pc_i (aligned down)
//   redirect_pc_i    redirect target byte address
//   imem_addr_o      instruction memory byte address (low IMEM_W bits of PC)
//   imem_instr_i     instruction word returned for imem_addr_o
//   if_pc_o          PC of the instruction held in IF/ID
//   if_pc4_o         if_pc_o + 4
//   if_instr_o       instruction held in IF/ID (NOP_INSTR when invalid)
//   if_valid_o       IF/ID holds a real instruction
//   misalign_o       one-cycle pulse: last redirect target was not word aligned
//   fetch_cnt_o      instructions captured into IF/ID since reset

module fetch_unit #(
    parameter int unsigned IMEM_W    = 13,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_pc4_o,
    output logic [31:0]       if_instr_o,
    output logic              if_valid_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_cnt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        capture;

    // A redirect or flush kills the wrong-path word even while stalled.
    assign capture = ~redirect_valid_i & ~flush_i & ~stall_i;

    // Next PC: redirect beats stall, otherwise sequential (wraps mod 2^32).
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state; PC fields hold on bubbles so decode sees a stable PC.
    always_comb begin
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        if (redirect_valid_i || flush_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (capture) begin
            if_pc_d     = pc_q;
            if_pc4_d    = pc_q + 32'd4;
            if_instr_d  = imem_instr_i;
            if_valid_d  = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    assign misalign_d = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= RESET_PC;
            if_pc_q     <= 32'h0000_0000;
            if_pc4_q    <= 32'h0000_0004;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_pc4_q    <= if_pc4_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Upper PC bits are dropped, so the memory address wraps.
    assign imem_addr_o = pc_q[IMEM_W-1:0];
    assign if_pc_o     = if_pc_q;
    assign if_pc4_o    = if_pc4_q;
    assign if_instr_o  = if_instr_q;
    assign if_valid_o  = if_valid_q;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule
